// File: rtl/rice_stream_decoder.sv
// +--------------------------------------------------------------------------+
// | rice_stream_decoder : bit-serial FLAC Rice decoder from a packed word RAM |
// | Optional: RICE_BITCOUNT_EN adds oBitsConsumed.   Revision: 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rice_stream_decoder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBaseAddress,
  input  logic [CNT_W-1:0]  iCount,
  input  logic [3:0]        iRiceParam,
  output logic              oRamEnable,
  output logic [ADDR_W-1:0] oRamAddress,
  input  logic [DATA_W-1:0] iRamData,
  output logic [DATA_W-1:0] oResidual,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oDone,
`ifdef RICE_BITCOUNT_EN
  output logic [31:0]       oBitsConsumed,
`endif
  output logic              oError
);

  localparam int BL_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_UNARY, S_BINARY, S_EMIT, S_DONE
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   count_q;
  logic [3:0]         k_q;
  logic [DATA_W-1:0]  sr_q;
  logic [BL_W-1:0]    bits_q;
  logic [DATA_W-1:0]  q_q;
  logic [DATA_W-1:0]  r_q;
  logic [3:0]         rem_q;
  logic               phase_q;
  logic               ram_en_q;
  logic [DATA_W-1:0]  res_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
`ifdef RICE_BITCOUNT_EN
  logic [31:0]        bitcnt_q;
`endif

  logic               bit_d;
  logic [BL_W-1:0]    bits_d;
  logic [DATA_W-1:0]  r_d;
  logic [DATA_W-1:0]  q_max_d;
  logic               empty_d;

  assign bit_d   = sr_q[DATA_W-1];
  assign bits_d  = bits_q - BL_W'(1);
  assign r_d     = {r_q[DATA_W-2:0], bit_d};
  assign empty_d = (bits_d == '0);
  // Largest quotient whose (q << k) still fits in DATA_W bits.
  assign q_max_d = {DATA_W{1'b1}} >> k_q;

  function automatic logic [DATA_W-1:0] unzig(input logic [DATA_W-1:0] u);
    return (u >> 1) ^ {DATA_W{u[0]}};
  endfunction

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      k_q      <= '0;
      sr_q     <= '0;
      bits_q   <= '0;
      q_q      <= '0;
      r_q      <= '0;
      rem_q    <= '0;
      phase_q  <= 1'b0;
      ram_en_q <= 1'b0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef RICE_BITCOUNT_EN
      bitcnt_q <= '0;
`endif
    end else begin
      ram_en_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef RICE_BITCOUNT_EN
      if (state_q == S_UNARY || state_q == S_BINARY) bitcnt_q <= bitcnt_q + 32'd1;
`endif
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            addr_q  <= iBaseAddress;
            count_q <= iCount;
            k_q     <= iRiceParam;
            err_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            phase_q <= 1'b0;
            bits_q  <= '0;
`ifdef RICE_BITCOUNT_EN
            bitcnt_q <= '0;
`endif
            if (iCount == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
              ram_en_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          sr_q    <= iRamData;
          bits_q  <= BL_W'(DATA_W);
          addr_q  <= addr_q + ADDR_W'(1);
          state_q <= phase_q ? S_BINARY : S_UNARY;
        end
        S_UNARY: begin
          sr_q   <= sr_q << 1;
          bits_q <= bits_d;
          if (!bit_d) begin
            if (q_q == q_max_d) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              q_q      <= q_q + DATA_W'(1);
              state_q  <= empty_d ? S_FETCH : S_UNARY;
              ram_en_q <= empty_d;
            end
          end else if (k_q == 4'd0) begin
            res_q   <= unzig(q_q);
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end else begin
            phase_q  <= 1'b1;
            rem_q    <= k_q;
            state_q  <= empty_d ? S_FETCH : S_BINARY;
            ram_en_q <= empty_d;
          end
        end
        S_BINARY: begin
          sr_q   <= sr_q << 1;
          bits_q <= bits_d;
          r_q    <= r_d;
          rem_q  <= rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            res_q   <= unzig((q_q << k_q) | r_d);
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end else begin
            state_q  <= empty_d ? S_FETCH : S_BINARY;
            ram_en_q <= empty_d;
          end
        end
        S_EMIT: begin
          if (iReady) begin
            valid_q <= 1'b0;
            count_q <= count_q - CNT_W'(1);
            q_q     <= '0;
            r_q     <= '0;
            phase_q <= 1'b0;
            if (count_q == CNT_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (bits_q == '0) begin
              state_q  <= S_FETCH;
              ram_en_q <= 1'b1;
            end else begin
              state_q <= S_UNARY;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oRamEnable  = ram_en_q;
  assign oRamAddress = addr_q;
  assign oResidual   = res_q;
  assign oValid      = valid_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oError      = err_q;
`ifdef RICE_BITCOUNT_EN
  assign oBitsConsumed = bitcnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/rice_stream_decoder.md
Name: rice_stream_decoder

Overview:
- Reads a packed FLAC Rice bitstream from a 16-bit-wide word RAM and reconstructs signed residuals. It is the inverse of the encode-side Rice encoder and packed-bit RAM writer.
- Decoding is bit-serial: one stream bit per cycle, one fixed Rice parameter per run, one residual per valid/ready handshake.
- It sits in the decode/verification path, where it feeds the LPC reconstruction stage or a bench scoreboard.

Parameters:
- DATA_W, 16, residual and RAM word width in bits
- ADDR_W, 16, RAM address width
- CNT_W, 16, width of the sample-count input

Ports:
- iClock  in  1  system clock, rising edge
- iReset  in  1  reset, asynchronous, active-low
- iStart  in  1  single-cycle run start; ignored unless IDLE
- iBaseAddress  in  ADDR_W  address of first stream word, sampled on iStart
- iCount  in  CNT_W  number of residuals to decode, sampled on iStart
- iRiceParam  in  4  Rice parameter k (0..15), sampled on iStart
- oRamEnable  out  1  RAM read strobe
- oRamAddress  out  ADDR_W  RAM read address
- iRamData  in  DATA_W  RAM read data, valid exactly 1 cycle after oRamEnable
- oResidual  out  DATA_W  decoded signed residual (two's complement)
- oValid  out  1  oResidual valid
- iReady  in  1  downstream accepts oResidual
- oBusy  out  1  high from the cycle after an accepted iStart until DONE
- oDone  out  1  single-cycle pulse when the run ends, normal or error
- oError  out  1  sticky quotient-overflow flag; cleared by reset or next iStart

Behaviour:

Reset:
- While iReset=0, all outputs are 0, state is IDLE, and all internal registers are cleared.
- Reset asserted mid-run aborts the run immediately. No oDone is issued.

Stream format:
- Bits are consumed MSB-first within each word. Words are read from consecutive addresses starting at iBaseAddress; the address wraps modulo 2^ADDR_W.
- Each code is q zero bits, then a 1 bit, then k remainder bits (MSB-first).
- u = (q << k) | r.
- Residual = (u >> 1) XOR -(u & 1), i.e. zigzag inverse: u=0→0, 1→-1, 2→1, 3→-2.

States:
- IDLE: on iStart, latch the inputs, clear oError, set word address = base.
  - If iCount=0 → DONE, with no RAM access.
  - Otherwise → FETCH.
- FETCH (1 cycle): oRamEnable=1 with oRamAddress = current address → WAIT.
- WAIT (1 cycle): load iRamData into the 16-bit shift register, set bitsLeft=16, increment the address.
  - Go to UNARY if the code is in its quotient phase, otherwise to BINARY.
- UNARY (1 bit/cycle):
  - On a 0 bit: q++.
  - On a 1 bit: if k=0 → EMIT, else → BINARY with rem count = k.
  - Overflow: if a 0 bit arrives while q == 2^(DATA_W-k)-1, set oError → DONE.
- BINARY (1 bit/cycle): shift the bit into r and decrement the rem count. When the count reaches 0 → EMIT.
- Word exhaustion: any bit consumption that empties the shift register (bitsLeft reaches 0) enters FETCH next cycle. The phase is remembered, so a code may span words. This costs 2 stall cycles per word.
- EMIT:
  - oResidual and oValid are registered in the cycle after the last bit of the code.
  - oValid and oResidual hold until a cycle where iReady=1; the handshake completes in that cycle.
  - Next cycle: decrement the remaining count. If it is 0 → DONE. Otherwise go to UNARY, or to FETCH if the buffer is empty. q and r are cleared.
  - No stream bits are consumed while in EMIT.
- DONE: oDone=1 for one cycle, oBusy=0 → IDLE.

Width and misc rules:
- u is formed in DATA_W bits; the overflow rule guarantees no truncation.
- A run always reads whole words. Trailing bits in the last word are ignored.
- iStart while oBusy=1 is ignored. An iRiceParam change mid-run has no effect.

Latency:
- From an accepted iStart to the first oRamEnable is 1 cycle.
- For a code of n bits contained in the current word, oValid rises n cycles after the first bit cycle.

Optional Feature:
- Macro RICE_BITCOUNT_EN.
- When defined: adds output oBitsConsumed (32 bits), the count of stream bits consumed in the current run.
  - Cleared on iStart.
  - Stable from oDone until the next iStart.
  - Excludes ignored trailing bits.
- When undefined: the port and counter are absent, with no other behavioural change.

Test Plan:
- Two codes in one word: k=2, count=2, RAM[0x10]=0x6E00, base=0x10, iReady=1 → outputs 3 then -2 (0xFFFE). Exactly one read, at address 0x10. oDone pulses once. With RICE_BITCOUNT_EN, oBitsConsumed=7.
- Word boundary: k=0, count=17, RAM[0x20]=0xFFFF, RAM[0x21]=0x8000 → 17 zero residuals. Reads at 0x20 then 0x21, with a 2-cycle stall before the 17th bit.
- Backpressure: the first test with iReady=0 for 5 cycles after the first oValid → oResidual=3 held stable for 6 cycles. No further bits consumed. Second output -2 follows.
- Overflow: k=15, count=1, RAM[0]=0x0000 → oError=1 on the second zero bit, oDone pulses, no oValid ever. oError stays until the next iStart.
- Edge and reset: count=0 → oDone one cycle after iStart with no oRamEnable. Separately, iReset low mid-BINARY → all outputs 0 immediately and no oDone. A new iStart after release decodes correctly from scratch.
